// File: rtl/muldiv_ctrl.sv
// Multi-cycle multiply/divide sequencer owning all HI/LO writes (MULT/MULTU/DIV/DIVU/MTHI/MTLO).
// Define MULDIV_FAST_MUL_EN for single-cycle combinational multiplies; division stays iterative.
module muldiv_ctrl #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] opa,
  input  logic [WIDTH-1:0] opb,
  input  logic [WIDTH-1:0] hi_i,
  input  logic [WIDTH-1:0] lo_i,
  input  logic             cancel,
  output logic             busy,
  output logic             hilo_we,
  output logic [WIDTH-1:0] hi_o,
  output logic [WIDTH-1:0] lo_o
);

  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_DONE} state_e;

  localparam logic [2:0] OP_MTHI = 3'b100;
  localparam logic [2:0] OP_MTLO = 3'b101;

  state_e               state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [2*WIDTH-1:0]   acc_q, acc_d;    // product {hi,lo} or {remainder,quotient}
  logic [WIDTH-1:0]     mcand_q, mcand_d; // multiplicand or divisor magnitude
  logic                 neg_q, neg_d;     // product / quotient sign
  logic                 rneg_q, rneg_d;   // remainder sign
  logic [WIDTH-1:0]     hi_q, hi_d;
  logic [WIDTH-1:0]     lo_q, lo_d;

  logic                 is_mul, is_div, is_signed, sa, sb, last;
  logic [WIDTH-1:0]     mag_a, mag_b;
  logic [WIDTH:0]       mul_sum, div_rs, div_diff;
  logic [2*WIDTH-1:0]   mul_next, div_next, mul_res;
`ifdef MULDIV_FAST_MUL_EN
  logic [2*WIDTH-1:0]   fast_a, fast_b, fast_prod;
`endif

  always_comb begin
    is_mul    = (op[2:1] == 2'b00);
    is_div    = (op[2:1] == 2'b01);
    is_signed = ~op[0];
    sa        = is_signed & opa[WIDTH-1];
    sb        = is_signed & opb[WIDTH-1];
    mag_a     = sa ? -opa : opa;
    mag_b     = sb ? -opb : opb;
    last      = (cnt_q == CNT_W'(WIDTH - 1));

    // Shift-add step: conditionally add multiplicand into the upper half, then shift right.
    mul_sum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, mcand_q};
    mul_next = acc_q[0] ? {mul_sum, acc_q[WIDTH-1:1]} : {1'b0, acc_q[2*WIDTH-1:1]};
    mul_res  = neg_q ? -mul_next : mul_next;

    // Restoring step: shift next dividend bit into remainder, keep the subtraction if it fits.
    div_rs   = acc_q[2*WIDTH-1:WIDTH-1];
    div_diff = div_rs - {1'b0, mcand_q};
    div_next = div_diff[WIDTH] ? {div_rs[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0}
                               : {div_diff[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
`ifdef MULDIV_FAST_MUL_EN
    fast_a    = is_signed ? {{WIDTH{opa[WIDTH-1]}}, opa} : {{WIDTH{1'b0}}, opa};
    fast_b    = is_signed ? {{WIDTH{opb[WIDTH-1]}}, opb} : {{WIDTH{1'b0}}, opb};
    fast_prod = fast_a * fast_b;
`endif
  end

  // NOTE: every next-state signal gets its hold value first, so no path can infer a latch.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    acc_d   = acc_q;
    mcand_d = mcand_q;
    neg_d   = neg_q;
    rneg_d  = rneg_q;
    hi_d    = hi_q;
    lo_d    = lo_q;

    if (cancel) begin
      state_d = S_IDLE;
    end else begin
      unique case (state_q)
        S_IDLE: if (start) begin
          if (is_mul) begin
`ifdef MULDIV_FAST_MUL_EN
            hi_d    = fast_prod[2*WIDTH-1:WIDTH];
            lo_d    = fast_prod[WIDTH-1:0];
            state_d = S_DONE;
`else
            acc_d   = {{WIDTH{1'b0}}, mag_b};
            mcand_d = mag_a;
            neg_d   = sa ^ sb;
            cnt_d   = '0;
            state_d = S_MUL;
`endif
          end else if (is_div) begin
            if (opb == '0) begin
              hi_d    = opa;
              lo_d    = '1;
              state_d = S_DONE;
            end else begin
              acc_d   = {{WIDTH{1'b0}}, mag_a};
              mcand_d = mag_b;
              neg_d   = sa ^ sb;
              rneg_d  = sa;
              cnt_d   = '0;
              state_d = S_DIV;
            end
          end else if (op == OP_MTHI) begin
            hi_d    = opa;
            lo_d    = lo_i;
            state_d = S_DONE;
          end else if (op == OP_MTLO) begin
            hi_d    = hi_i;
            lo_d    = opa;
            state_d = S_DONE;
          end
        end
        S_MUL: begin
          acc_d = mul_next;
          cnt_d = cnt_q + CNT_W'(1);
          if (last) begin
            hi_d    = mul_res[2*WIDTH-1:WIDTH];
            lo_d    = mul_res[WIDTH-1:0];
            state_d = S_DONE;
          end
        end
        S_DIV: begin
          acc_d = div_next;
          cnt_d = cnt_q + CNT_W'(1);
          if (last) begin
            hi_d    = rneg_q ? -div_next[2*WIDTH-1:WIDTH] : div_next[2*WIDTH-1:WIDTH];
            lo_d    = neg_q  ? -div_next[WIDTH-1:0]       : div_next[WIDTH-1:0];
            state_d = S_DONE;
          end
        end
        S_DONE: state_d = S_IDLE;
        default: state_d = S_IDLE;
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      acc_q   <= '0;
      mcand_q <= '0;
      neg_q   <= 1'b0;
      rneg_q  <= 1'b0;
      hi_q    <= '0;
      lo_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      acc_q   <= acc_d;
      mcand_q <= mcand_d;
      neg_q   <= neg_d;
      rneg_q  <= rneg_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
    end
  end

  // Combinational so the issuing instruction stalls from its very first EX cycle.
  always_comb begin
`ifdef MULDIV_FAST_MUL_EN
    busy = ((state_q == S_IDLE) && start && !cancel && is_div && (opb != '0))
`else
    busy = ((state_q == S_IDLE) && start && !cancel && (is_mul || (is_div && (opb != '0))))
`endif
        || (state_q == S_MUL) || (state_q == S_DIV);
    hilo_we = (state_q == S_DONE) && !cancel;
    hi_o    = hi_q;
    lo_o    = lo_q;
  end

endmodule
